// File: rtl/line_buffer_taps_pkg.sv
// Shared helpers for the multi-tap line buffer and downstream window stages.
// Tap k of a packed tap bus sits at bits [k*w +: w].
`ifndef LBT_TAP
`define LBT_TAP(bus, k, w) bus[(k)*(w) +: (w)]
`endif

package line_buffer_taps_pkg;

  localparam int unsigned LEN_W = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Zero or oversize lengths fall back to the full RAM depth.
  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] x,
    input int unsigned      max_len
  );
    if (x == '0 || 32'(x) > max_len) return LEN_W'(max_len);
    return x;
  endfunction

endpackage

// File: rtl/line_buffer_taps_ram.sv
// One circular delay line: read-before-write, registered dout, no reset.
// rdata exposes the evicted word so the next line can be chained in-cycle.
module line_delay_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clock) begin
    if (we) begin
      dout      <= mem[addr];
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/line_buffer_taps.sv
// Multi-tap line delay: current pixel plus co-located pixels of the
// previous TAP_NUM-1 lines, with fill masking and a valid flag.
module line_buffer_taps
  import line_buffer_taps_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  parameter int LINE_LENGTH = 640,
  parameter int TAP_NUM     = 3
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic                           clken,
  input  logic                           sof,
  input  logic [15:0]                    active_len,
  input  logic [INPUT_WIDTH-1:0]         shiftin,
  output logic [TAP_NUM*INPUT_WIDTH-1:0] taps,
  output logic                           taps_valid
);

  localparam int unsigned PTR_W  = clog2(LINE_LENGTH);
  localparam int unsigned FILL_W = clog2(TAP_NUM);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAP_NUM - 1);

  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       wr_addr;
  logic [FILL_W-1:0]      fill_cnt;
  logic [FILL_W-1:0]      fill_eff;
  logic [LEN_W-1:0]       len_reg;
  logic [LEN_W-1:0]       len_eff;
  logic                   loaded;
  logic                   wrap;
  logic [INPUT_WIDTH-1:0] tap0;
  logic [TAP_NUM-1:1]     mask;
  logic [INPUT_WIDTH-1:0] chain [TAP_NUM];
  logic [INPUT_WIDTH-1:0] dout [1:TAP_NUM-1];

  // First edge after reset release behaves like sof for the length.
  always_comb begin
    len_eff = len_reg;
    if (sof || !loaded) len_eff = clamp_len(active_len, LINE_LENGTH);
    wr_addr  = sof ? '0 : ptr;
    fill_eff = sof ? '0 : fill_cnt;
    wrap     = (LEN_W'(wr_addr) == len_eff - 16'd1);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      fill_cnt   <= '0;
      len_reg    <= LEN_W'(LINE_LENGTH);
      loaded     <= 1'b0;
      tap0       <= '0;
      mask       <= '0;
      taps_valid <= 1'b0;
    end else begin
      loaded     <= 1'b1;
      len_reg    <= len_eff;
      taps_valid <= clken && (fill_eff == FILL_MAX);
      if (clken) begin
        ptr  <= wrap ? '0 : wr_addr + 1'b1;
        tap0 <= shiftin;
        if (wrap && fill_eff != FILL_MAX)
          fill_cnt <= fill_eff + 1'b1;
        else
          fill_cnt <= fill_eff;
        for (int k = 1; k < TAP_NUM; k++)
          mask[k] <= (32'(fill_eff) >= k);
      end else if (sof) begin
        ptr      <= '0;
        fill_cnt <= '0;
      end
    end
  end

  assign chain[0] = shiftin;
  assign `LBT_TAP(taps, 0, INPUT_WIDTH) = tap0;

  for (genvar k = 1; k < TAP_NUM; k++) begin : g_line
    line_delay_ram #(
      .WIDTH (INPUT_WIDTH),
      .DEPTH (LINE_LENGTH),
      .AW    (PTR_W)
    ) u_ram (
      .clock (clock),
      .we    (clken),
      .addr  (wr_addr),
      .din   (chain[k-1]),
      .dout  (dout[k]),
      .rdata (chain[k])
    );
    assign `LBT_TAP(taps, k, INPUT_WIDTH) = mask[k] ? dout[k] : '0;
  end

endmodule

// File: tb/tb_line_buffer_taps.sv
// Directed bench for line_buffer_taps (W=8, LINE_LENGTH=8, TAP_NUM=3).
module tb_line_buffer_taps;

  logic        clock;
  logic        rst_n;
  logic        clken;
  logic        sof;
  logic [15:0] active_len;
  logic [7:0]  shiftin;
  logic [23:0] taps;
  logic        taps_valid;

  int checks = 0;
  int errors = 0;

  line_buffer_taps #(
    .INPUT_WIDTH (8),
    .LINE_LENGTH (8),
    .TAP_NUM     (3)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .clken      (clken),
    .sof        (sof),
    .active_len (active_len),
    .shiftin    (shiftin),
    .taps       (taps),
    .taps_valid (taps_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ce, input logic s, input logic [7:0] d);
    @(negedge clock);
    clken   = ce;
    sof     = s;
    shiftin = d;
    @(posedge clock);
    #1;
  endtask

  // Pixel values equal their index within the frame.
  function automatic logic [31:0] exp3(input int i, input int len);
    logic [7:0] t0, t1, t2;
    t0 = 8'(i);
    t1 = (i > len) ? 8'(i - len) : 8'h00;
    t2 = (i > 2 * len) ? 8'(i - 2 * len) : 8'h00;
    return {8'h00, t2, t1, t0};
  endfunction

  initial begin
    rst_n = 1'b1;
    clken = 1'b0;
    sof = 1'b0;
    active_len = 16'd4;
    shiftin = 8'h00;
    #1 rst_n = 1'b0;
    #20;
    chk("reset_taps", 32'(taps), 32'h0);
    chk("reset_valid", 32'(taps_valid), 32'h0);
    @(negedge clock) rst_n = 1'b1;

    // fill and steady state, len 4
    step(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk("t1_taps", 32'(taps), exp3(i, 4));
      chk("t1_valid", 32'(taps_valid), 32'(i >= 9));
      if (i == 9) chk("t1_first", 32'(taps), 32'h010509);
      if (i == 12) chk("t1_last", 32'(taps), 32'h04080c);
    end

    // gapped clken
    step(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk("t2_taps", 32'(taps), exp3(i, 4));
      chk("t2_valid", 32'(taps_valid), 32'(i >= 9));
      step(1'b0, 1'b0, 8'hee);
      chk("t2_hold", 32'(taps), exp3(i, 4));
      chk("t2_gap_valid", 32'(taps_valid), 32'h0);
    end

    // masking after reset with stale RAM
    @(negedge clock) rst_n = 1'b0;
    #1;
    chk("t3_rst_taps", 32'(taps), 32'h0);
    @(negedge clock) rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk("t3_taps", 32'(taps), exp3(i, 4));
      chk("t3_valid", 32'(taps_valid), 32'h0);
    end
    chk("t3_p5", 32'(taps), 32'h000105);

    // mid-line sof with clken, new len 2
    step(1'b1, 1'b0, 8'h06);
    active_len = 16'd2;
    step(1'b1, 1'b1, 8'haa);
    chk("t4_sof_taps", 32'(taps), 32'h0000aa);
    chk("t4_sof_valid", 32'(taps_valid), 32'h0);
    step(1'b1, 1'b0, 8'h11);
    chk("t4_p2", 32'(taps), 32'h000011);
    chk("t4_p2_valid", 32'(taps_valid), 32'h0);
    step(1'b1, 1'b0, 8'h22);
    chk("t4_p3", 32'(taps), 32'h00aa22);
    chk("t4_p3_valid", 32'(taps_valid), 32'h0);
    step(1'b1, 1'b0, 8'h33);
    chk("t4_p4", 32'(taps), 32'h001133);
    chk("t4_p4_valid", 32'(taps_valid), 32'h0);
    step(1'b1, 1'b0, 8'h44);
    chk("t4_p5", 32'(taps), 32'haa2244);
    chk("t4_p5_valid", 32'(taps_valid), 32'h1);

    // clamp: len 0 -> 8
    active_len = 16'd0;
    step(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk("t5_zero_taps", 32'(taps), exp3(i, 8));
    end
    chk("t5_zero_tap1", 32'(taps[15:8]), 32'h01);

    // clamp: len 20 -> 8, mid-frame length change ignored
    active_len = 16'd20;
    step(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 8'(i + 'h40));
      if (i == 4) active_len = 16'd3;
      if (i == 8) chk("t5_big_p8", 32'(taps[15:8]), 32'h00);
      if (i == 9) chk("t5_big_p9", 32'(taps[15:8]), 32'h41);
      if (i == 10) chk("t5_big_p10", 32'(taps[15:8]), 32'h42);
    end

    // len 1: every advance wraps
    active_len = 16'd1;
    step(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk("len1_taps", 32'(taps), exp3(i, 1));
      chk("len1_valid", 32'(taps_valid), 32'(i >= 3));
    end

    // async reset between edges
    step(1'b1, 1'b0, 8'h05);
    chk("t6_pre_valid", 32'(taps_valid), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_taps", 32'(taps), 32'h0);
    chk("t6_valid", 32'(taps_valid), 32'h0);
    clken = 1'b0;
    #20 rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
